// File: rtl/regfile_pkg.sv
// Shared sizing, address type and zero-register constant for the CPU register file.
package regfile_pkg;
  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_DEPTH  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, zero/out-of-range masking, optional write forwarding.
// Forwarding of the same-edge write is enabled by REGFILE_BYPASS_EN.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_WIDTH,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  regs [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
`endif
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid
);

  logic             in_range_c;
  logic             is_zero_c;
  logic [WIDTH-1:0] sel_data_c;

  // Select the operand; register 0 and unmapped addresses read as zero.
  always_comb begin
    sel_data_c = '0;
    in_range_c = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
    is_zero_c  = (rd_addr == ADDR_W'(ZERO_REG));
    if (in_range_c && !is_zero_c) begin
      sel_data_c = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes address 0 and unmapped addresses.
      if (wr_en && (wr_addr == rd_addr)) begin
        sel_data_c = wr_data;
      end
`endif
    end
  end

  // Data holds when the port is idle; valid tracks the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= sel_data_c;
      end
    end
  end

endmodule

// File: rtl/register_file_read.sv
// Two-read, one-write register file with registered read data and valid strobes.
// REGFILE_BYPASS_EN forwards a same-edge write to a read of the same address.
module register_file_read
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_WIDTH,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              RdValidB
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_en_c;

  // Writes to register 0 or to unmapped addresses are dropped.
  always_comb begin
    wr_en_c = Load
              && (WrAddr != ADDR_W'(ZERO_REG))
              && ({1'b0, WrAddr} < (ADDR_W+1)'(DEPTH));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs[WrAddr] <= WrData;
    end
  end

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
    .clk      (Clk),
    .rst_n    (Reset),
    .rd_en    (RdEnA),
    .rd_addr  (RdAddrA),
    .regs     (regs),
`ifdef REGFILE_BYPASS_EN
    .wr_en    (wr_en_c),
    .wr_addr  (WrAddr),
    .wr_data  (WrData),
`endif
    .rd_data  (RdDataA),
    .rd_valid (RdValidA)
  );

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
    .clk      (Clk),
    .rst_n    (Reset),
    .rd_en    (RdEnB),
    .rd_addr  (RdAddrB),
    .regs     (regs),
`ifdef REGFILE_BYPASS_EN
    .wr_en    (wr_en_c),
    .wr_addr  (WrAddr),
    .wr_data  (WrData),
`endif
    .rd_data  (RdDataB),
    .rd_valid (RdValidB)
  );

endmodule

// File: tb/tb_register_file_read.sv
// Directed bench for register_file_read: reset, read/write, zero reg, bypass, dual read, async reset.
module tb_register_file_read;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Load;
  logic [AW-1:0] WrAddr;
  logic [W-1:0]  WrData;
  logic          RdEnA, RdEnB;
  logic [AW-1:0] RdAddrA, RdAddrB;
  logic [W-1:0]  RdDataA, RdDataB;
  logic          RdValidA, RdValidB;

  int vectors    = 0;
  int miscompares = 0;

  register_file_read dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .WrData(WrData),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdValidA(RdValidA),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(RdDataB), .RdValidB(RdValidB)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [W-1:0] bypass_exp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'h22;
`else
    bypass_exp = 32'h11;
`endif
    Reset = 1'b0; Load = 1'b0; WrAddr = '0; WrData = '0;
    RdEnA = 1'b0; RdAddrA = '0; RdEnB = 1'b0; RdAddrB = '0;
    step(); step();
    check("rst_data_a", RdDataA, 32'h0);
    check("rst_valid_a", {31'b0, RdValidA}, 32'h0);
    check("rst_valid_b", {31'b0, RdValidB}, 32'h0);

    // Release between edges, then read r5 / r31.
    Reset = 1'b1;
    RdEnA = 1'b1; RdAddrA = 5'd5; RdEnB = 1'b1; RdAddrB = 5'd31;
    step();
    check("post_rst_a", RdDataA, 32'h0);
    check("post_rst_b", RdDataB, 32'h0);
    check("post_rst_va", {31'b0, RdValidA}, 32'h1);
    check("post_rst_vb", {31'b0, RdValidB}, 32'h1);

    // Write r7, read it back, then idle the port.
    RdEnA = 1'b0; RdEnB = 1'b0;
    Load = 1'b1; WrAddr = 5'd7; WrData = 32'hDEADBEEF;
    step();
    check("idle_va", {31'b0, RdValidA}, 32'h0);
    check("idle_vb", {31'b0, RdValidB}, 32'h0);
    Load = 1'b0; RdEnA = 1'b1; RdAddrA = 5'd7;
    step();
    check("r7_data", RdDataA, 32'hDEADBEEF);
    check("r7_valid", {31'b0, RdValidA}, 32'h1);
    RdEnA = 1'b0; RdAddrA = 5'd5;
    step();
    check("hold_valid", {31'b0, RdValidA}, 32'h0);
    check("hold_data", RdDataA, 32'hDEADBEEF);

    // Write to r0 is discarded.
    Load = 1'b1; WrAddr = 5'd0; WrData = 32'h12345678;
    step();
    Load = 1'b0;
    RdEnA = 1'b1; RdAddrA = 5'd0; RdEnB = 1'b1; RdAddrB = 5'd0;
    step();
    check("r0_a", RdDataA, 32'h0);
    check("r0_b", RdDataB, 32'h0);
    RdEnA = 1'b0; RdEnB = 1'b0;

    // Same-edge read/write of r3.
    Load = 1'b1; WrAddr = 5'd3; WrData = 32'h11;
    step();
    WrData = 32'h22; RdEnA = 1'b1; RdAddrA = 5'd3;
    step();
    check("bypass_same_edge", RdDataA, bypass_exp);
    Load = 1'b0;
    step();
    check("bypass_next", RdDataA, 32'h22);
    RdEnA = 1'b0;

    // Dual read of the same address.
    Load = 1'b1; WrAddr = 5'd9; WrData = 32'hAA;
    step();
    Load = 1'b0;
    RdEnA = 1'b1; RdAddrA = 5'd9; RdEnB = 1'b1; RdAddrB = 5'd9;
    step();
    check("dual_a", RdDataA, 32'hAA);
    check("dual_b", RdDataB, 32'hAA);
    RdEnB = 1'b0;
    step();
    check("cont_a", RdDataA, 32'hAA);
    check("b_off_valid", {31'b0, RdValidB}, 32'h0);

    // Async reset between edges, no clock edge needed.
    #2 Reset = 1'b0;
    #1;
    check("async_data_a", RdDataA, 32'h0);
    check("async_valid_a", {31'b0, RdValidA}, 32'h0);
    step();
    check("rst_hold_valid", {31'b0, RdValidA}, 32'h0);
    Reset = 1'b1;
    step();
    check("after_rst_r9", RdDataA, 32'h0);
    check("after_rst_valid", {31'b0, RdValidA}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
